// File: rtl/ipm_distributed_sync_fifo_v1_3.sv
// Single-clock distributed-RAM FIFO with optional FWFT read and water-level flags.
// Define IPM_SYNC_FIFO_ERR_FLAG_EN to build the sticky overflow/underflow flags.
module ipm_distributed_sync_fifo_v1_3 #(
  parameter int ADDR_WIDTH       = 10,
  parameter int DATA_WIDTH       = 32,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 4,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_water_level,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_water_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AF_LVL = LW'(DEPTH - ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AE_LVL = LW'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  wr_acc;
  logic                  rd_acc;

  // Level never exceeds DEPTH, so its MSB alone marks full.
  assign level          = wr_ptr - rd_ptr;
  assign full           = level[ADDR_WIDTH];
  assign empty          = (level == '0);
  assign almost_full    = (level >= AF_LVL);
  assign almost_empty   = (level <= AE_LVL);
  assign wr_water_level = level;
  assign rd_water_level = level;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Masked while empty so stale RAM never shows after reset.
      assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (rst) rd_q <= '0;
        else if (rd_acc) rd_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
      assign rd_data = rd_q;
    end
  endgenerate

`ifdef IPM_SYNC_FIFO_ERR_FLAG_EN
  logic ovf_q;
  logic unf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en & full) ovf_q <= 1'b1;
      if (rd_en & empty) unf_q <= 1'b1;
    end
  end
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
